hazard_ctrl_sb: RTL
===================

HAZARD_CTRL_SB -- requirements
Module: hazard_ctrl_sb

Interface
REQ-001 Parameter RA_W, default 4: register-address width; register 0 is hard-wired zero.
REQ-002 Parameter NSRC, default 2: number of source operands checked per decoded instruction.
REQ-003 Parameter MUL_LAT, default 3: busy cycles of a long-latency (multiply) result, range 1..15.
REQ-004 Parameter FLUSH_CYC, default 1: cycles the front-end clean signals stay asserted after a jump, range 1..7.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 run  in  1  core running; 0 disables all hazard actions.
REQ-008 if_id_src  in  NSRC*RA_W  source register addresses of the IF/ID instruction, operand i at bits [i*RA_W +: RA_W].
REQ-009 if_id_src_vld  in  NSRC  per-operand "operand is read" flag; replaces the rs-only special cases.
REQ-010 id_ex_RegWrite, id_ex_MemRead  in  1 each  ID/EX control bits.
REQ-011 id_ex_Rd  in  RA_W  ID/EX destination.
REQ-012 id_ex_mul  in  1  ID/EX instruction is long-latency; its result bypasses the forwarding network.
REQ-013 ex_mem_RegWrite  in  1; ex_mem_Rd  in  RA_W  EX/MEM write-back info.
REQ-014 doJump  in  1  taken jump/branch/call/return resolved this cycle.
REQ-015 fwd  out  2*NSRC  per operand, 00 none, 01 EX, 10 MEM; 11 never driven.
REQ-016 stall, pc_write_en, if_id_write_en, if_id_clean, id_ex_clean, ex_mem_clean, flushing  out  1 each.

Function
REQ-017 ex_match[i] = src_vld[i] & id_ex_RegWrite & !id_ex_mul & id_ex_Rd!=0 & src[i]==id_ex_Rd; mem_match[i] = the same test against ex_mem_RegWrite/ex_mem_Rd (no mul term).
REQ-018 fwd[i] = 01 if ex_match[i] & !id_ex_MemRead; else 10 if mem_match[i] & !ex_match[i]; else 00.
REQ-019 A load-use stall is asserted when any ex_match[i] & id_ex_MemRead.
REQ-020 The scoreboard holds one busy counter per register, 0..MUL_LAT; register 0 is never busy.
REQ-021 A scoreboard stall is asserted when any valid source register has a nonzero counter, or when id_ex_mul & id_ex_RegWrite & id_ex_Rd==src[i].
REQ-022 The counter for id_ex_Rd loads MUL_LAT when id_ex_mul & id_ex_RegWrite & id_ex_Rd!=0 & !doJump & state==IDLE.
REQ-023 Every other nonzero counter decrements by 1 per cycle; a load takes precedence over a decrement on the same register.
REQ-024 stall = (load-use | scoreboard) & run & !doJump & state==IDLE.
REQ-025 pc_write_en and if_id_write_en = !stall.
REQ-026 id_ex_clean = clean | stall; if_id_clean and ex_mem_clean = clean.
REQ-027 clean = run & (doJump | state==FLUSH).
REQ-028 The FSM has two states: IDLE and FLUSH. IDLE goes to FLUSH on run & doJump when FLUSH_CYC>1, with fcnt=FLUSH_CYC-1.
REQ-029 In FLUSH, fcnt decrements each cycle and the FSM returns to IDLE when fcnt reaches 1; doJump in FLUSH reloads fcnt=FLUSH_CYC-1.
REQ-030 flushing = state==FLUSH.
REQ-031 run=0 forces fwd=0 and stall=0; counters still decrement, and the FSM is held in IDLE.
REQ-032 A multiply already in flight is not cancelled by a jump; its counter keeps running.

Reset
REQ-033 rst clears all counters and fcnt to 0 and sets the FSM to IDLE; it overrides any simultaneous load, decrement or doJump.
REQ-034 In the reset cycle and the cycle after it, with idle inputs: stall=0, pc_write_en=1, if_id_write_en=1, all clean outputs=0, flushing=0, fwd=0.

Structure
REQ-035 A shared package hz_pkg holds fwd encodings (FWD_NONE, FWD_EX, FWD_MEM), the FSM state type, and default parameter constants.
REQ-036 The per-register counter array is one sub-module, hz_scoreboard (load/decrement/busy-lookup), instantiated once.

Verification
REQ-037 Case 1: id_ex Rd=3, RegWrite=1, MemRead=0, src0=3 -> fwd[1:0]=01, stall=0.
REQ-038 Case 2: same as case 1 but MemRead=1 -> stall=1, pc_write_en=0, id_ex_clean=1; next cycle with Rd in ex_mem, fwd=10, stall=0.
REQ-039 Case 3: MUL_LAT=3, mul to r5, src1=5 -> stall for exactly 4 consecutive cycles (the ID/EX cycle plus 3 counter cycles), then released.
REQ-040 Case 4: FLUSH_CYC=3, doJump pulse -> if_id/id_ex/ex_mem_clean high for 3 cycles, flushing high for cycles 2-3; a second doJump in cycle 2 extends the window to cycle 4.
REQ-041 Case 5: doJump concurrent with load-use -> stall=0 and clean=1; a mul in ID/EX squashed by the jump leaves its counter at 0.
REQ-042 Case 6: rst asserted mid-mul (counter=2) -> counter reads 0 the next cycle and no stall occurs; Rd=0 or src_vld=0 never forwards or stalls.

Source files
------------

// File: rtl/hz_pkg.sv
// rtl/hz_pkg.sv - shared types and constants for the hazard controller
// Purpose: forwarding-select encodings, FSM state type, default parameters.
// Ports: none (package).
package hz_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EX   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_e;

  localparam int RA_W_DEF      = 4;
  localparam int NSRC_DEF      = 2;
  localparam int MUL_LAT_DEF   = 3;
  localparam int FLUSH_CYC_DEF = 1;

  // Busy counters hold 0..15, flush counter holds 0..7.
  localparam int CNT_W  = 4;
  localparam int FCNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_sb_if.sv
// rtl/hazard_ctrl_sb_if.sv - pipeline-to-hazard-controller signal bundle
// Purpose: groups the decode/execute/memory hazard inputs and the control outputs.
// Ports: master = pipeline side (drives stage info, receives controls);
//        slave  = hazard controller (receives stage info, drives controls).
interface hazard_ctrl_sb_if #(
  parameter int RA_W = 4,
  parameter int NSRC = 2
);
  logic                 run;
  logic [NSRC*RA_W-1:0] if_id_src;
  logic [NSRC-1:0]      if_id_src_vld;
  logic                 id_ex_RegWrite;
  logic                 id_ex_MemRead;
  logic [RA_W-1:0]      id_ex_Rd;
  logic                 id_ex_mul;
  logic                 ex_mem_RegWrite;
  logic [RA_W-1:0]      ex_mem_Rd;
  logic                 doJump;
  logic [2*NSRC-1:0]    fwd;
  logic                 stall;
  logic                 pc_write_en;
  logic                 if_id_write_en;
  logic                 if_id_clean;
  logic                 id_ex_clean;
  logic                 ex_mem_clean;
  logic                 flushing;

  modport master (
    output run, if_id_src, if_id_src_vld, id_ex_RegWrite, id_ex_MemRead,
           id_ex_Rd, id_ex_mul, ex_mem_RegWrite, ex_mem_Rd, doJump,
    input  fwd, stall, pc_write_en, if_id_write_en, if_id_clean,
           id_ex_clean, ex_mem_clean, flushing
  );

  modport slave (
    input  run, if_id_src, if_id_src_vld, id_ex_RegWrite, id_ex_MemRead,
           id_ex_Rd, id_ex_mul, ex_mem_RegWrite, ex_mem_Rd, doJump,
    output fwd, stall, pc_write_en, if_id_write_en, if_id_clean,
           id_ex_clean, ex_mem_clean, flushing
  );

endinterface

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - per-register busy counters for long-latency results
// Purpose: one down-counter per architectural register; load, decrement, lookup.
// Ports: clk, rst (sync active-high); i_load/i_load_rd start a busy window;
//        i_src = packed source addresses; o_busy = per-source nonzero-counter flag.
module hz_scoreboard
  import hz_pkg::*;
#(
  parameter int RA_W    = RA_W_DEF,
  parameter int NSRC    = NSRC_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [RA_W-1:0]      i_load_rd,
  input  logic [NSRC*RA_W-1:0] i_src,
  output logic [NSRC-1:0]      o_busy
);

  localparam int NREG = 1 << RA_W;

  logic [CNT_W-1:0] r_cnt [NREG];

  // Load wins over decrement on the same register; register 0 stays at zero.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (rst || r == 0) begin
        r_cnt[r] <= '0;
      end else if (i_load && i_load_rd == RA_W'(r)) begin
        r_cnt[r] <= CNT_W'(MUL_LAT);
      end else if (r_cnt[r] != '0) begin
        r_cnt[r] <= r_cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    o_busy = '0;
    for (int i = 0; i < NSRC; i++) begin
      o_busy[i] = (r_cnt[i_src[i*RA_W +: RA_W]] != '0);
    end
  end

endmodule

// File: rtl/hazard_ctrl_sb.sv
// rtl/hazard_ctrl_sb.sv - forwarding, load-use/scoreboard stall and flush control
// Purpose: selects forwarding paths, stalls decode on load-use or busy multiply
//          results, and drives front-end clean signals after taken jumps.
// Ports: clk, rst (sync active-high); bus (hazard_ctrl_sb_if.slave) carries
//        stage info in and fwd/stall/write-enable/clean/flushing out.
module hazard_ctrl_sb
  import hz_pkg::*;
#(
  parameter int RA_W      = RA_W_DEF,
  parameter int NSRC      = NSRC_DEF,
  parameter int MUL_LAT   = MUL_LAT_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_sb_if.slave bus
);

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [FCNT_W-1:0] r_fcnt;
  logic [FCNT_W-1:0] w_fcnt_nxt;

  logic [NSRC-1:0] w_ex_match;
  logic [NSRC-1:0] w_mem_match;
  logic [NSRC-1:0] w_busy;
  logic            w_load_use;
  logic            w_sb_stall;
  logic            w_idle;
  logic            w_load;
  logic            w_stall;
  logic            w_clean;

  assign w_idle = (r_state == ST_IDLE);

  // A multiply squashed by a same-cycle jump, or issued while flushing, never
  // reaches the scoreboard.
  assign w_load = bus.id_ex_mul & bus.id_ex_RegWrite & (bus.id_ex_Rd != '0)
                & ~bus.doJump & w_idle;

  hz_scoreboard #(
    .RA_W   (RA_W),
    .NSRC   (NSRC),
    .MUL_LAT(MUL_LAT)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_load_rd(bus.id_ex_Rd),
    .i_src    (bus.if_id_src),
    .o_busy   (w_busy)
  );

  always_comb begin
    w_ex_match  = '0;
    w_mem_match = '0;
    w_load_use  = 1'b0;
    w_sb_stall  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      // Multiply results are not forwardable; they are covered by the scoreboard.
      w_ex_match[i]  = bus.if_id_src_vld[i] & bus.id_ex_RegWrite & ~bus.id_ex_mul
                     & (bus.id_ex_Rd != '0)
                     & (bus.if_id_src[i*RA_W +: RA_W] == bus.id_ex_Rd);
      w_mem_match[i] = bus.if_id_src_vld[i] & bus.ex_mem_RegWrite
                     & (bus.ex_mem_Rd != '0)
                     & (bus.if_id_src[i*RA_W +: RA_W] == bus.ex_mem_Rd);
      w_load_use     = w_load_use | (w_ex_match[i] & bus.id_ex_MemRead);
      // Second term covers the multiply sitting in ID/EX before its counter loads.
      w_sb_stall     = w_sb_stall
                     | (bus.if_id_src_vld[i] & w_busy[i])
                     | (bus.if_id_src_vld[i] & bus.id_ex_mul & bus.id_ex_RegWrite
                        & (bus.id_ex_Rd != '0)
                        & (bus.if_id_src[i*RA_W +: RA_W] == bus.id_ex_Rd));
    end
  end

  always_comb begin
    bus.fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!bus.run) begin
        bus.fwd[2*i +: 2] = FWD_NONE;
      end else if (w_ex_match[i] && !bus.id_ex_MemRead) begin
        bus.fwd[2*i +: 2] = FWD_EX;
      end else if (w_mem_match[i] && !w_ex_match[i]) begin
        bus.fwd[2*i +: 2] = FWD_MEM;
      end else begin
        bus.fwd[2*i +: 2] = FWD_NONE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // FSM next state. r_fcnt counts the flush cycles still to come, including
  // the current one; FLUSH is left once the last one has been spent.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (!bus.run) begin
      w_state_nxt = ST_IDLE;
      w_fcnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.doJump && FLUSH_CYC > 1) begin
            w_state_nxt = ST_FLUSH;
            w_fcnt_nxt  = FCNT_W'(FLUSH_CYC - 1);
          end
        end
        ST_FLUSH: begin
          if (bus.doJump) begin
            w_fcnt_nxt = FCNT_W'(FLUSH_CYC - 1);
          end else if (r_fcnt <= FCNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_fcnt_nxt  = '0;
          end else begin
            w_fcnt_nxt = r_fcnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_fcnt_nxt  = '0;
        end
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    w_clean            = bus.run & (bus.doJump | ~w_idle);
    w_stall            = (w_load_use | w_sb_stall) & bus.run & ~bus.doJump & w_idle;
    bus.stall          = w_stall;
    bus.pc_write_en    = ~w_stall;
    bus.if_id_write_en = ~w_stall;
    bus.if_id_clean    = w_clean;
    bus.id_ex_clean    = w_clean | w_stall;
    bus.ex_mem_clean   = w_clean;
    bus.flushing       = ~w_idle;
  end

endmodule
